// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] iload;

  modport master (output imemREN, output imemaddr, input ihit, input iload);
  modport slave  (input imemREN, input imemaddr, output ihit, output iload);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, next-PC select, IF/ID latch, halt FSM and fetch counter.
//   state | meaning
//   FETCH | PC advances under pcen, memory read requested, IF/ID loads under deen
//   HALT  | terminal until nRST; PC frozen, no read request, IF/ID loads only bubbles
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 pcen,
  input  logic                 deen,
  input  logic                 deflush,
  input  logic [1:0]           PCSel,
  input  logic [31:0]          jr_target,
  input  logic [25:0]          j_index,
  input  logic [31:0]          br_target,
  input  logic                 halt,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_d,
  output logic [31:0]          pcplus4_d,
  output logic                 valid_d,
  output logic                 halted,
  output logic [31:0]          fetch_count
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t      state, next_state;
  logic [31:0] pc, pc4, next_pc;
  logic        halt_take, pc_we, load_valid;

  always_comb begin
    pc4        = pc + 32'd4;
    next_pc    = pc4;
    case (PCSel)
      2'd0: next_pc = pc4;
      2'd1: next_pc = {jr_target[31:2], 2'b00};
      // the jump is resolved in decode, so its region bits come from the latched PC+4
      2'd2: next_pc = {pcplus4_d[31:28], j_index, 2'b00};
      2'd3: next_pc = {br_target[31:2], 2'b00};
      default: next_pc = pc4;
    endcase

    next_state = state;
    halt_take  = (state == FETCH) && halt && !deflush;
    if (halt_take) next_state = HALT;

    pc_we      = (state == FETCH) && pcen && !halt_take;
    load_valid = !deflush && deen && (state == FETCH);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      pc <= PC_INIT;
    else if (pc_we) pc <= next_pc;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_d   <= '0;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (deflush || (deen && state == HALT)) begin
      instr_d   <= '0;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (load_valid) begin
      instr_d   <= imem.iload;
      pcplus4_d <= pc4;
      valid_d   <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)           fetch_count <= '0;
    else if (load_valid) fetch_count <= fetch_count + 32'd1;
  end

  assign imem.imemREN  = (state == FETCH);
  assign imem.imemaddr = pc;
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main sequence plus reset and wrap sequences.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        pcen, deen, deflush, halt, ihit;
  logic [1:0]  PCSel;
  logic [31:0] jr_target, br_target, iload;
  logic [25:0] j_index;
  logic        wrap_pcen, wrap_deen;

  logic [31:0] instr_d, pcplus4_d, fetch_count;
  logic        valid_d, halted;
  logic [31:0] w_instr_d, w_pcplus4_d, w_fetch_count;
  logic        w_valid_d, w_halted;

  int checks = 0;
  int errors = 0;

  fetch_stage_if ibus ();
  fetch_stage_if wbus ();
  assign ibus.ihit  = ihit;
  assign ibus.iload = iload;
  assign wbus.ihit  = ihit;
  assign wbus.iload = iload;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0000_0000)) u_dut (
    .CLK(CLK), .nRST(nRST), .pcen(pcen), .deen(deen), .deflush(deflush), .PCSel(PCSel),
    .jr_target(jr_target), .j_index(j_index), .br_target(br_target), .halt(halt),
    .imem(ibus.master), .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .halted(halted), .fetch_count(fetch_count));

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .nRST(nRST), .pcen(wrap_pcen), .deen(wrap_deen), .deflush(1'b0), .PCSel(2'd0),
    .jr_target(jr_target), .j_index(j_index), .br_target(br_target), .halt(1'b0),
    .imem(wbus.master), .instr_d(w_instr_d), .pcplus4_d(w_pcplus4_d), .valid_d(w_valid_d),
    .halted(w_halted), .fetch_count(w_fetch_count));

  typedef struct {
    logic        pcen, deen, deflush, halt, ihit;
    logic [1:0]  sel;
    logic [31:0] iload, jr, br;
    logic [25:0] jidx;
    logic [31:0] e_addr, e_instr, e_p4;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_halted;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // pcen deen dfl halt ihit sel iload jr br jidx | addr instr p4 valid cnt halted
    vecs[0]  = '{1,1,0,0,1,2'd0,32'hA000_0000,32'h0,32'h0,26'h0,           32'h0000_0004,32'hA000_0000,32'h0000_0004,1,32'd1,0};
    vecs[1]  = '{1,1,0,0,1,2'd0,32'hA000_0004,32'h0,32'h0,26'h0,           32'h0000_0008,32'hA000_0004,32'h0000_0008,1,32'd2,0};
    vecs[2]  = '{0,0,0,0,0,2'd0,32'hDEAD_BEEF,32'h0,32'h0,26'h0,           32'h0000_0008,32'hA000_0004,32'h0000_0008,1,32'd2,0};
    vecs[3]  = '{0,0,0,0,0,2'd0,32'hDEAD_BEEF,32'h0,32'h0,26'h0,           32'h0000_0008,32'hA000_0004,32'h0000_0008,1,32'd2,0};
    vecs[4]  = '{0,0,0,0,0,2'd0,32'hDEAD_BEEF,32'h0,32'h0,26'h0,           32'h0000_0008,32'hA000_0004,32'h0000_0008,1,32'd2,0};
    vecs[5]  = '{1,1,0,0,1,2'd0,32'hA000_0008,32'h0,32'h0,26'h0,           32'h0000_000C,32'hA000_0008,32'h0000_000C,1,32'd3,0};
    vecs[6]  = '{1,1,0,0,1,2'd0,32'hA000_000C,32'h0,32'h0,26'h0,           32'h0000_0010,32'hA000_000C,32'h0000_0010,1,32'd4,0};
    vecs[7]  = '{1,1,0,0,1,2'd3,32'hA000_0010,32'h0,32'h1000_000F,26'h0,   32'h1000_000C,32'hA000_0010,32'h0000_0014,1,32'd5,0};
    vecs[8]  = '{1,1,0,0,1,2'd0,32'hB000_000C,32'h0,32'h0,26'h0,           32'h1000_0010,32'hB000_000C,32'h1000_0010,1,32'd6,0};
    vecs[9]  = '{1,1,1,0,1,2'd2,32'hB000_0010,32'h0,32'h0,26'h0000040,     32'h1000_0100,32'h0000_0000,32'h0000_0000,0,32'd6,0};
    vecs[10] = '{1,1,0,0,1,2'd1,32'hC000_0000,32'h0000_0203,32'h0000_0777,26'h3FFFFFF, 32'h0000_0200,32'hC000_0000,32'h1000_0104,1,32'd7,0};
    vecs[11] = '{1,1,0,0,1,2'd3,32'hC000_0200,32'h0000_0333,32'h0000_0040,26'h3FFFFFF, 32'h0000_0040,32'hC000_0200,32'h0000_0204,1,32'd8,0};
    vecs[12] = '{0,0,1,0,0,2'd0,32'h0,32'h0,32'h0,26'h0,                   32'h0000_0040,32'h0000_0000,32'h0000_0000,0,32'd8,0};
    vecs[13] = '{1,1,1,1,1,2'd0,32'hD000_0040,32'h0,32'h0,26'h0,           32'h0000_0044,32'h0000_0000,32'h0000_0000,0,32'd8,0};
    vecs[14] = '{1,1,0,0,1,2'd1,32'hD000_0044,32'h0000_0014,32'h0,26'h0,   32'h0000_0014,32'hD000_0044,32'h0000_0048,1,32'd9,0};
    vecs[15] = '{1,1,0,1,1,2'd0,32'hD000_0014,32'h0,32'h0,26'h0,           32'h0000_0014,32'hD000_0014,32'h0000_0018,1,32'd10,1};
    vecs[16] = '{1,1,0,0,1,2'd0,32'hE000_0000,32'h0,32'h0,26'h0,           32'h0000_0014,32'h0000_0000,32'h0000_0000,0,32'd10,1};
    vecs[17] = '{1,0,0,0,1,2'd3,32'hE000_0004,32'h0,32'h0000_0800,26'h0,   32'h0000_0014,32'h0000_0000,32'h0000_0000,0,32'd10,1};

    nRST = 1'b0; pcen = 0; deen = 0; deflush = 0; halt = 0; ihit = 0; PCSel = 2'd0;
    jr_target = '0; br_target = '0; j_index = '0; iload = '0; wrap_pcen = 0; wrap_deen = 0;
    #12;
    chk("rst addr",   ibus.imemaddr, 32'h0);
    chk("rst ren",    {31'b0, ibus.imemREN}, 32'd1);
    chk("rst instr",  instr_d, 32'h0);
    chk("rst p4",     pcplus4_d, 32'h0);
    chk("rst valid",  {31'b0, valid_d}, 32'd0);
    chk("rst count",  fetch_count, 32'd0);
    chk("rst halted", {31'b0, halted}, 32'd0);
    chk("rst wrap addr", wbus.imemaddr, 32'hFFFF_FFFC);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      pcen = vecs[i].pcen; deen = vecs[i].deen; deflush = vecs[i].deflush; halt = vecs[i].halt;
      ihit = vecs[i].ihit; PCSel = vecs[i].sel; iload = vecs[i].iload;
      jr_target = vecs[i].jr; br_target = vecs[i].br; j_index = vecs[i].jidx;
      step();
      chk($sformatf("v%0d addr", i),   ibus.imemaddr, vecs[i].e_addr);
      chk($sformatf("v%0d instr", i),  instr_d, vecs[i].e_instr);
      chk($sformatf("v%0d p4", i),     pcplus4_d, vecs[i].e_p4);
      chk($sformatf("v%0d valid", i),  {31'b0, valid_d}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d count", i),  fetch_count, vecs[i].e_cnt);
      chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
      chk($sformatf("v%0d ren", i),    {31'b0, ibus.imemREN}, {31'b0, ~vecs[i].e_halted});
    end

    // asynchronous reset while halted, with a read still being returned
    #3;
    nRST = 1'b0;
    #1;
    chk("arst halted", {31'b0, halted}, 32'd0);
    chk("arst addr",   ibus.imemaddr, 32'h0);
    chk("arst count",  fetch_count, 32'd0);
    chk("arst valid",  {31'b0, valid_d}, 32'd0);
    step();
    chk("arst hold addr", ibus.imemaddr, 32'h0);
    chk("arst hold instr", instr_d, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    pcen = 0; deen = 0; halt = 0; ihit = 0; PCSel = 2'd0;
    step();
    chk("post rst ren", {31'b0, ibus.imemREN}, 32'd1);

    // PC wrap past the top of the address space
    wrap_pcen = 1; wrap_deen = 1; ihit = 1; iload = 32'h1234_5678;
    step();
    wrap_pcen = 0; wrap_deen = 0; ihit = 0;
    chk("wrap addr",  wbus.imemaddr, 32'h0);
    chk("wrap p4",    w_pcplus4_d, 32'h0);
    chk("wrap instr", w_instr_d, 32'h1234_5678);
    chk("wrap valid", {31'b0, w_valid_d}, 32'd1);
    chk("wrap count", w_fetch_count, 32'd1);
    chk("idle main addr", ibus.imemaddr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, selects the next PC, drives the instruction-memory read request and holds the IF/ID pipeline latch. It sits directly upstream of the hazard unit's control point. It consumes that unit's `pcen`, `deen`, `deflush` and `PCSel` decisions and feeds the decode stage. It also runs a halt state machine and a fetched-instruction counter.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `pcen`  in  1  PC write enable from the hazard unit.
- `deen`  in  1  IF/ID latch load enable.
- `deflush`  in  1  IF/ID latch clear to bubble.
- `PCSel`  in  2  next-PC select: 0 = PC+4, 1 = jr target, 2 = jump, 3 = branch.
- `jr_target`  in  32  register value for jr, from decode.
- `j_index`  in  26  jump instruction index field, from decode.
- `br_target`  in  32  resolved branch target, from execute.
- `halt`  in  1  decode has a halt opcode.
- `ihit`  in  1  instruction memory read complete this cycle.
- `iload`  in  32  instruction memory read data, valid when `ihit`=1.
- `imemREN`  out  1  instruction memory read request.
- `imemaddr`  out  32  instruction memory address.
- `instr_d`  out  32  IF/ID latched instruction.
- `pcplus4_d`  out  32  IF/ID latched PC+4.
- `valid_d`  out  1  IF/ID holds a real (non-bubble) instruction.
- `halted`  out  1  the stage is in the HALT state.
- `fetch_count`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- **Next-PC arithmetic.** All arithmetic is unsigned, modulo 2^32.
  - `pc4` = PC + 4; it wraps: 32'hFFFF_FFFC + 4 = 0.
  - PCSel 0: next = `pc4`.
  - PCSel 1: next = {`jr_target`[31:2], 2'b00}. The low bits are forced to zero.
  - PCSel 2: next = {`pcplus4_d`[31:28], `j_index`, 2'b00}. The jump sits in decode, so the region bits come from the latched PC+4.
  - PCSel 3: next = {`br_target`[31:2], 2'b00}.
- **PC register.**
  - On reset, PC = `PC_INIT`.
  - In FETCH, if `pcen`=1, PC <= next. Otherwise PC holds.
  - In HALT, PC holds unconditionally.
- **Memory request.** `imemREN` = (state==FETCH). `imemaddr` = PC, combinational from the register.
- **IF/ID latch.** Priority order:
  1. `deflush`=1: `instr_d` <= 0, `pcplus4_d` <= 0, `valid_d` <= 0. This applies regardless of `deen`.
  2. Else if `deen`=1 and state==FETCH: `instr_d` <= `iload`, `pcplus4_d` <= `pc4`, `valid_d` <= 1.
  3. Else if `deen`=1 and state==HALT: load a bubble (all zero, `valid_d`=0).
  4. Else: hold.
- **Halt FSM.** Two states, FETCH and HALT.
  - Reset enters FETCH.
  - FETCH -> HALT on an edge where `halt`=1 and `deflush`=0. If `deflush` is also 1, the halt is on a squashed path and is ignored.
  - HALT is terminal; only `nRST` exits it.
  - `halted` = (state==HALT).
- **fetch_count.**
  - Increments by 1 on each edge where the latch takes the "load" branch with `valid_d` <= 1.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Frozen in HALT.
- **Input assumptions.** The stage does not gate `pcen`/`deen` with `ihit` itself; the hazard unit already does. When `ihit`=0, `iload` is don't-care and the stage relies on `deen`=0.

## Timing
- **Reset values** (async assert, sync behaviour after release): PC=`PC_INIT`, `instr_d`=0, `pcplus4_d`=0, `valid_d`=0, state=FETCH, `halted`=0, `fetch_count`=0, `imemREN`=1, `imemaddr`=`PC_INIT`.
- **Redirect latency.** A redirect (PCSel≠0 with `pcen`=1) takes effect at the next edge. `imemaddr` shows the target in the following cycle: 1-cycle redirect, no extra bubble beyond the hazard unit's `deflush`.
- **Fetch latency.** Fetch → decode is 1 edge: the instruction returned with `ihit` in cycle N appears on `instr_d` in cycle N+1.
- **Simultaneous events.**
  - `pcen`=1 with `deflush`=1 (taken branch/jump): PC redirects and IF/ID becomes a bubble on the same edge.
  - `halt`=1 with `pcen`=1: HALT wins and PC does not advance.
- **Reset mid-operation.** Asserting `nRST` immediately forces all reset values, including during a stall or in HALT. Any outstanding `ihit` is ignored.

## Test plan
- **Sequential fetch.** Reset with PC_INIT=0, hold `pcen`=`deen`=`ihit`=1, PCSel=0, `iload`=addr-tagged words. Required:
  - `imemaddr` reads 0, 4, 8, 12.
  - `instr_d`/`pcplus4_d` follow one cycle behind.
  - `fetch_count`=4 after 4 loads.
- **Stall.** Drop `ihit`, `pcen`, `deen` for 3 cycles at PC=8. Required: `imemaddr` stays 8, `instr_d` holds, `fetch_count` unchanged.
- **Jump.** `pcplus4_d`=32'h1000_0010, `j_index`=26'h0000040, PCSel=2, `pcen`=1, `deflush`=1. Required next cycle: `imemaddr`=32'h1000_0100, `valid_d`=0, `instr_d`=0.
- **jr / branch.**
  - PCSel=1 with `jr_target`=32'h0000_0203 → `imemaddr`=32'h0000_0200.
  - PCSel=3 with `br_target`=32'h0000_0040 → `imemaddr`=32'h0000_0040.
- **Wrap.**
  - PC_INIT=32'hFFFF_FFFC, one advance → `imemaddr`=0 and `pcplus4_d`=0.
  - `fetch_count` forced near max (via 2^32 is impractical; use increment check at small values plus a formal wrap check).
- **Halt.**
  - `halt`=1 with `pcen`=1 at PC=20. Required: `halted`=1, `imemREN`=0, PC stays 20, later loads are bubbles.
  - `halt`=1 with `deflush`=1: stays FETCH.
  - `nRST` pulse returns to FETCH with PC=PC_INIT.
